alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two, >= 8.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount bits taken from b_in.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a_in  input  WIDTH  operand A.
REQ-008 b_in  input  WIDTH  operand B.
REQ-009 ALUControl  input  4  opcode.
REQ-010 out_valid  output  1  ALUResult/Z hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 ALUResult  output  WIDTH  registered result.
REQ-013 Z  output  1  registered flag, 1 when ALUResult == 0.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Opcodes SHALL be: 0000 add, 0001 sub (two's complement), 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 mul (low WIDTH bits), 1011 mulhu (high WIDTH bits, unsigned), 1100 divu, 1101 remu; 1110/1111 SHALL produce ALUResult 0, Z 1.
REQ-016 Add/sub/mul SHALL wrap modulo 2^WIDTH; no carry/overflow outputs.
REQ-017 Shifts SHALL use b_in[SHAMT_W-1:0] only; sra SHALL replicate a_in[WIDTH-1].
REQ-018 slt/sltu SHALL return 1 or 0 zero-extended to WIDTH.
REQ-019 FSM states IDLE, CALC, DONE; transfer on input occurs when in_valid && in_ready; operands and opcode SHALL be captured at transfer.
REQ-020 in_ready SHALL be high only in IDLE.
REQ-021 IDLE -> DONE on transfer of a single-cycle opcode (0000-1001, 1110, 1111): out_valid high the cycle after transfer (latency 1).
REQ-022 IDLE -> CALC on transfer of opcodes 1010-1101; CALC SHALL run exactly WIDTH iteration cycles (shift-add multiply, restoring divide, one bit per cycle), then -> DONE; out_valid high WIDTH+1 cycles after transfer.
REQ-023 DONE: ALUResult, Z, out_valid SHALL stay stable until out_valid && out_ready; then -> IDLE, out_valid low next cycle.
REQ-024 in_valid while not in_ready SHALL be ignored; a_in/b_in/ALUControl changes after transfer SHALL NOT affect the result.
REQ-025 divu with b_in == 0 SHALL return all ones; remu with b_in == 0 SHALL return a_in; both still take WIDTH+1 cycles.
REQ-026 Z SHALL be computed from the final result written in the same cycle as ALUResult.
REQ-027 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-028 reset SHALL force state IDLE, out_valid 0, ALUResult 0, Z 1, busy 0, in_ready 1 on the next edge, from any state.
REQ-029 reset during CALC or DONE SHALL discard the operation; no result SHALL be presented afterwards.
REQ-030 reset SHALL take priority over transfer and over out_ready in the same cycle.

Structure
REQ-031 Package alu_pkg SHALL hold the 4-bit opcode constants and the FSM state enumeration.
REQ-032 Iterative mul/div datapath SHALL be sub-module alu_muldiv_iter (start, op, operands, done, result), sharing clk/reset.
REQ-033 Single-cycle ops SHALL remain combinational in alu_mc feeding the result register.

Verification
REQ-034 WIDTH=32: add 0xFFFFFFFF+1 -> ALUResult 0, Z 1, out_valid 1 cycle after transfer.
REQ-035 sra 0x80000000 by b_in=0x24 (shamt 4) -> 0xF8000000; slt 0xFFFFFFFF,1 -> 1; sltu same -> 0.
REQ-036 mul 0x10000,0x10000 -> 0, Z 1; mulhu same -> 0x1; out_valid exactly 33 cycles after transfer, in_ready low throughout.
REQ-037 divu 100,7 -> 14; remu 100,7 -> 2; divu 5,0 -> 0xFFFFFFFF; remu 5,0 -> 5.
REQ-038 Hold out_ready low 5 cycles in DONE, toggle inputs and pulse in_valid -> result unchanged, no new transfer; then out_ready 1 -> IDLE next cycle.
REQ-039 Assert reset at CALC cycle 10 of a divu -> next cycle IDLE, out_valid 0, ALUResult 0, Z 1; following add 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for alu_mc.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Opcodes served by the iterative mul/div unit rather than the single-cycle path.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing a hi/lo register pair.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

    logic               active_q, active_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_div;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic               take;
    logic [WIDTH-1:0]   hi_step, lo_step;

    // Multiply: hi accumulates, lo shifts out multiplier bits and in product bits.
    // Divide: hi is the partial remainder, lo shifts out dividend bits and in quotient bits.
    // A zero divisor naturally yields quotient all-ones and remainder == dividend.
    always_comb begin
        is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        take    = rem_sh >= {1'b0, opnd_q};
        if (is_div) begin
            hi_step = take ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], take};
        end else begin
            hi_step = sum[WIDTH:1];
            lo_step = {sum[0], lo_q[WIDTH-1:1]};
        end

        active_d = active_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            op_d     = op;
            opnd_d   = b_in;
            hi_d     = '0;
            lo_d     = a_in;
        end else if (active_q) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + SHAMT_W'(1);
            if (cnt_q == LAST) active_d = 1'b0;
        end

        done   = active_q && (cnt_q == LAST);
        result = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_step : lo_step;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops registered at transfer, mul/div iterated WIDTH cycles.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Z,
    output logic             busy
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d;

    logic               xfer;
    logic               iter_start;
    logic               iter_done;
    logic [WIDTH-1:0]   iter_result;
    logic [WIDTH-1:0]   alu_res;
    logic [SHAMT_W-1:0] shamt;

    alu_muldiv_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
        .op     (ALUControl),
        .a_in   (a_in),
        .b_in   (b_in),
        .done   (iter_done),
        .result (iter_result)
    );

    always_comb begin
        shamt   = b_in[SHAMT_W-1:0];
        alu_res = '0;
        case (ALUControl)
            OP_ADD:  alu_res = a_in + b_in;
            OP_SUB:  alu_res = a_in - b_in;
            OP_AND:  alu_res = a_in & b_in;
            OP_OR:   alu_res = a_in | b_in;
            OP_XOR:  alu_res = a_in ^ b_in;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            OP_SLL:  alu_res = a_in << shamt;
            OP_SRL:  alu_res = a_in >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a_in) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        xfer       = in_valid && in_ready;
        iter_start = xfer && is_iter_op(ALUControl);

        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        case (state_q)
            ST_IDLE: begin
                if (iter_start) begin
                    state_d = ST_CALC;
                end else if (xfer) begin
                    state_d  = ST_DONE;
                    result_d = alu_res;
                    z_d      = (alu_res == '0);
                end
            end
            ST_CALC: begin
                if (iter_done) begin
                    state_d  = ST_DONE;
                    result_d = iter_result;
                    z_d      = (iter_result == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            z_q      <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
        end
    end

    assign ALUResult = result_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in, b_in;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Z;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Z          (Z),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [63:0] p;
        int          sh;
        longint      sa;
        p  = 64'(a) * 64'(b);
        sh = int'(b % W);
        sa = longint'($signed(a));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd6:  return (a < b) ? 1 : 0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return W'(sa / (64'sd1 <<< sh) - ((sa < 0 && (sa % (64'sd1 <<< sh)) != 0) ? 1 : 0));
            4'd10: return p[W-1:0];
            4'd11: return p[2*W-1:W];
            4'd12: return (b == 0) ? '1 : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer one op, scramble inputs afterwards, measure latency, hold DONE a few cycles, then consume.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp;
        int           lat;
        int           exp_lat;
        logic         ir_bad;
        exp     = ref_op(op, a, b);
        exp_lat = (op >= 4'd10 && op <= 4'd13) ? W + 1 : 1;
        ir_bad  = 1'b0;
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        a_in       = a;
        b_in       = b;
        ALUControl = op;
        tick();
        lat = 1;
        while (!out_valid && lat < 3 * W) begin
            if (in_ready || !busy) ir_bad = 1'b1;
            in_valid   = 1'($urandom);
            a_in       = $urandom;
            b_in       = $urandom;
            ALUControl = 4'($urandom);
            tick();
            lat++;
        end
        in_valid   = 1'b0;
        a_in       = $urandom;
        b_in       = $urandom;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_ready_low_calc"}, 64'(ir_bad), 64'd0);
        chk({tag, "_result"}, 64'(ALUResult), 64'(exp));
        chk({tag, "_z"}, 64'(Z), 64'(exp == '0));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a_in     = $urandom;
            tick();
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_result"}, 64'(ALUResult), 64'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_consumed"}, 64'({out_valid, in_ready, busy}), 64'b010);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        ALUControl = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", 64'({out_valid, in_ready, busy, Z}), 64'b0101);
        chk("reset_result", 64'(ALUResult), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_ready_idle", 64'({out_valid, in_ready}), 64'b01);

        do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sra", 4'd9, 32'h8000_0000, 32'h24, 0);
        do_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("mul", 4'd10, 32'h1_0000, 32'h1_0000, 0);
        do_op("mulhu", 4'd11, 32'h1_0000, 32'h1_0000, 0);
        do_op("divu", 4'd12, 32'd100, 32'd7, 0);
        do_op("remu", 4'd13, 32'd100, 32'd7, 0);
        do_op("divu0", 4'd12, 32'd5, 32'd0, 0);
        do_op("remu0", 4'd13, 32'd5, 32'd0, 0);
        do_op("op14", 4'd14, 32'd9, 32'd3, 0);
        do_op("op15", 4'd15, 32'hFFFF_FFFF, 32'd3, 0);
        do_op("hold5", 4'd4, 32'h1234_5678, 32'h0F0F_0F0F, 5);

        for (int k = 0; k < 150; k++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 40));
                1: ra = 32'($urandom_range(0, 3)) << 30;
                default: ;
            endcase
            do_op("rand", 4'($urandom), ra, rb, $urandom_range(0, 2));
        end

        // Reset in the 10th CALC cycle of a divide discards it.
        in_valid   = 1'b1;
        a_in       = 32'd1000;
        b_in       = 32'd3;
        ALUControl = 4'd12;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("calc_busy", 64'({busy, in_ready}), 64'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_calc_state", 64'({out_valid, in_ready, busy, Z}), 64'b0101);
        chk("rst_calc_result", 64'(ALUResult), 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < W + 8; i++) begin
                tick();
                if (out_valid) seen = 1'b1;
            end
            chk("rst_no_result", 64'(seen), 64'd0);
        end
        do_op("add_after_rst", 4'd0, 32'd2, 32'd3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
